// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the Uart8 transmit/receive control blocks.
package uart_ctrl_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } arbState_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Producer-side handshake and Uart8 tx-side signals of the shared transmitter arbiter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import uart_ctrl_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]             reqValid;
    logic [UART_BYTE_W*NUM_REQ-1:0] reqData;
    logic [NUM_REQ-1:0]             reqReady;
    logic [NUM_REQ-1:0]             sentDone;
    logic [NUM_REQ-1:0]             sentErr;
    logic [IDX_W-1:0]               grantId;
    logic                           busy;
    logic                           txEn;
    logic                           txStart;
    logic [UART_BYTE_W-1:0]         txIn;
    logic                           txBusy;
    logic                           txDone;

    // Master is the surrounding system: the producers plus the Uart8 status lines.
    modport master (
        output reqValid, reqData, txBusy, txDone,
        input  reqReady, sentDone, sentErr, grantId, busy, txEn, txStart, txIn
    );

    modport slave (
        input  reqValid, reqData, txBusy, txDone,
        output reqReady, sentDone, sentErr, grantId, busy, txEn, txStart, txIn
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping around.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any
);

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int cand;
            cand = (int'(ptr) + i) % NUM_REQ;
            if (!any && req[cand]) begin
                any              = 1'b1;
                gnt_idx          = IDX_W'(cand);
                gnt_onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one Uart8 transmitter among NUM_REQ byte producers,
// with start timeout and optional idle gap between bytes.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int GAP_CYCLES    = 0,
    parameter int START_TIMEOUT = 1024
) (
    input logic              clk,
    input logic              reset,
    uart_tx_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TO_W  = $clog2(START_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(START_TIMEOUT - 1);
    localparam logic [15:0]     GAP_LAST = 16'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

    arbState_e              state_q, state_d;
    logic [IDX_W-1:0]       grantId_q, grantId_d;
    logic [IDX_W-1:0]       rrPtr_q, rrPtr_d;
    logic [UART_BYTE_W-1:0] txIn_q, txIn_d;
    logic [TO_W-1:0]        toCnt_q, toCnt_d;
    logic [15:0]            gapCnt_q, gapCnt_d;
    logic [NUM_REQ-1:0]     sentDone_q, sentDone_d;
    logic [NUM_REQ-1:0]     sentErr_q, sentErr_d;

    logic [NUM_REQ-1:0]     pickOnehot;
    logic [IDX_W-1:0]       pickIdx;
    logic                   pickAny;
    logic [NUM_REQ-1:0]     reqReady;
    logic                   txStart;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) uPick (
        .req        (bus.reqValid),
        .ptr        (rrPtr_q),
        .gnt_onehot (pickOnehot),
        .gnt_idx    (pickIdx),
        .any        (pickAny)
    );

    // Granting waits for txBusy low so a frame left in flight across reset is never overrun;
    // reqReady is also masked while reset is held so it reads zero during reset.
    always_comb begin
        state_d    = state_q;
        grantId_d  = grantId_q;
        rrPtr_d    = rrPtr_q;
        txIn_d     = txIn_q;
        toCnt_d    = toCnt_q;
        gapCnt_d   = gapCnt_q;
        sentDone_d = '0;
        sentErr_d  = '0;
        reqReady   = '0;
        txStart    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pickAny && !bus.txBusy && !reset) begin
                    reqReady  = pickOnehot;
                    txIn_d    = bus.reqData[pickIdx*UART_BYTE_W +: UART_BYTE_W];
                    grantId_d = pickIdx;
                    rrPtr_d   = (pickIdx == IDX_W'(NUM_REQ - 1)) ? '0 : pickIdx + 1'b1;
                    toCnt_d   = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (bus.txBusy) begin
                    state_d = WAIT_DONE;
                end else begin
                    txStart = 1'b1;
                    if (toCnt_q >= TO_LAST) begin
                        sentErr_d[grantId_q] = 1'b1;
                        state_d              = IDLE;
                    end else begin
                        toCnt_d = toCnt_q + 1'b1;
                    end
                end
            end
            WAIT_DONE: begin
                if (!bus.txBusy && bus.txDone) begin
                    sentDone_d[grantId_q] = 1'b1;
                    gapCnt_d              = '0;
                    state_d               = (GAP_CYCLES > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (gapCnt_q >= GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gapCnt_d = gapCnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            grantId_q  <= '0;
            rrPtr_q    <= '0;
            txIn_q     <= '0;
            toCnt_q    <= '0;
            gapCnt_q   <= '0;
            sentDone_q <= '0;
            sentErr_q  <= '0;
        end else begin
            state_q    <= state_d;
            grantId_q  <= grantId_d;
            rrPtr_q    <= rrPtr_d;
            txIn_q     <= txIn_d;
            toCnt_q    <= toCnt_d;
            gapCnt_q   <= gapCnt_d;
            sentDone_q <= sentDone_d;
            sentErr_q  <= sentErr_d;
        end
    end

    assign bus.reqReady = reqReady;
    assign bus.sentDone = sentDone_q;
    assign bus.sentErr  = sentErr_q;
    assign bus.grantId  = grantId_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.txEn     = 1'b1;
    assign bus.txStart  = txStart;
    assign bus.txIn     = txIn_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter against a small behavioural Uart8 transmitter
// (10-cycle frames, txDone held high between frames).
module tb_uart_tx_arbiter;

    localparam int FRAME = 10;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int passCnt  = 0;
    int checkCnt = 0;
    int failCnt  = 0;

    uart_tx_arbiter_if #(.NUM_REQ(4)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ       (4),
        .GAP_CYCLES    (100),
        .START_TIMEOUT (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Uart8 stand-in: not touched by the arbiter reset, so frames survive it.
    logic       uBusy     = 1'b0;
    logic       uDone     = 1'b0;
    logic       uartDead  = 1'b0;
    int         frameLeft = 0;
    logic [7:0] shiftByte = 8'h00;
    logic [7:0] rxLog[$];

    assign bus.txBusy = uBusy;
    assign bus.txDone = uDone;

    always @(posedge clk) begin
        if (uartDead) begin
            uBusy <= 1'b0;
        end else if (frameLeft != 0) begin
            frameLeft <= frameLeft - 1;
            if (frameLeft == 1) begin
                uBusy <= 1'b0;
                uDone <= 1'b1;
                rxLog.push_back(shiftByte);
            end
        end else if (bus.txEn && bus.txStart) begin
            uBusy     <= 1'b1;
            uDone     <= 1'b0;
            frameLeft <= FRAME;
            shiftByte <= bus.txIn;
        end
    end

    int readyCnt[4];

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (bus.reqReady[i]) readyCnt[i]++;
        end
    end

    logic [3:0] expOrder[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0] expBytes[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] data);
        bus.reqValid = valid;
        bus.reqData  = data;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCnt++;
        assert (observed === expected) passCnt++;
        else begin
            failCnt++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] rxAt(input int idx);
        if (idx >= 0 && idx < rxLog.size()) return rxLog[idx];
        return 8'hxx;
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         n;
        int         base1;
        int         base3;
        int         startRx;
        logic [3:0] g;
        logic [3:0] vld;
        logic [31:0] dat;

        // Reset with all requests raised: nothing may be accepted.
        applyStimulus(4'hF, 32'h44332211);
        repeat (3) tick();
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_txEn", bus.txEn, 1);
        checkOutput("rst_txStart", bus.txStart, 0);
        checkOutput("rst_txIn", bus.txIn, 0);
        checkOutput("rst_reqReady", bus.reqReady, 0);
        checkOutput("rst_pulses", {bus.sentDone, bus.sentErr}, 0);
        checkOutput("rst_grantId", bus.grantId, 0);

        applyStimulus(4'h0, 32'h0);
        reset = 1'b0;
        tick();

        // Single byte from requester 2, with a second byte queued behind it.
        base1 = readyCnt[1];
        applyStimulus(4'b0100, 32'h008A0000);
        checkOutput("single_ready", bus.reqReady, 4'b0100);
        tick();
        checkOutput("single_grantId", bus.grantId, 2);
        checkOutput("single_txStart", bus.txStart, 1);
        checkOutput("single_txIn", bus.txIn, 8'h8A);
        checkOutput("single_busy", bus.busy, 1);
        applyStimulus(4'b0100, 32'h005B0000);
        tick();
        checkOutput("start_drop", bus.txStart, 0);
        applyStimulus(4'b0110, 32'h005B6600);
        tick();
        applyStimulus(4'b0100, 32'h005B0000);
        for (n = 0; n < 60 && bus.sentDone == 0; n++) tick();
        checkOutput("single_done", bus.sentDone, 4'b0100);
        checkOutput("single_rx", rxAt(rxLog.size() - 1), 8'h8A);
        checkOutput("txIn_hold", bus.txIn, 8'h8A);

        // Gap between sentDone and the next grant.
        tick();
        n = 1;
        checkOutput("done_one_cycle", bus.sentDone, 0);
        while (bus.reqReady == 0 && n < 200) begin
            tick();
            n++;
        end
        checkOutput("gap_len", n, 100);
        checkOutput("regrant_single", bus.reqReady, 4'b0100);
        tick();
        applyStimulus(4'h0, 32'h0);
        for (n = 0; n < 60 && bus.sentDone == 0; n++) tick();
        checkOutput("second_done", bus.sentDone, 4'b0100);
        checkOutput("second_rx", rxAt(rxLog.size() - 1), 8'h5B);
        checkOutput("withdrawn_ignored", readyCnt[1] - base1, 0);

        // Reset while a frame is in flight.
        applyStimulus(4'b0001, 32'h00000077);
        for (n = 0; n < 200 && bus.reqReady == 0; n++) tick();
        checkOutput("mid_ready", bus.reqReady, 4'b0001);
        tick();
        applyStimulus(4'b1000, 32'hC3000000);
        for (n = 0; n < 10 && bus.txBusy == 0; n++) tick();
        checkOutput("mid_txBusy", bus.txBusy, 1);
        tick();
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_busy", bus.busy, 0);
        checkOutput("mid_rst_txStart", bus.txStart, 0);
        checkOutput("mid_rst_pulses", {bus.sentDone, bus.sentErr, bus.reqReady}, 0);
        checkOutput("mid_rst_grantId", bus.grantId, 0);
        base3 = readyCnt[3];
        tick();
        reset = 1'b0;
        #1;
        checkOutput("post_rst_hold", bus.reqReady, 0);
        for (n = 0; n < 20 && bus.txBusy == 1; n++) tick();
        checkOutput("post_rst_no_early_grant", readyCnt[3] - base3, 0);
        checkOutput("post_rst_grant", bus.reqReady, 4'b1000);
        tick();
        applyStimulus(4'h0, 32'h0);
        for (n = 0; n < 60 && bus.sentDone == 0; n++) tick();
        checkOutput("post_rst_done", bus.sentDone, 4'b1000);
        checkOutput("inflight_rx", rxAt(rxLog.size() - 2), 8'h77);
        checkOutput("post_rst_rx", rxAt(rxLog.size() - 1), 8'hC3);

        // Contention from a clean pointer, with requester 0 returning during byte 1.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        startRx = rxLog.size();
        vld = 4'hF;
        dat = 32'h44332211;
        applyStimulus(vld, dat);
        for (int k = 0; k < 5; k++) begin
            for (n = 0; n < 200 && bus.reqReady == 0; n++) tick();
            checkOutput($sformatf("order_%0d", k), bus.reqReady, expOrder[k]);
            g = bus.reqReady;
            tick();
            vld = vld & ~g;
            if (k == 1) begin
                vld[0]    = 1'b1;
                dat[7:0]  = 8'h55;
            end
            applyStimulus(vld, dat);
        end
        for (n = 0; n < 60 && bus.sentDone == 0; n++) tick();
        checkOutput("contend_last_done", bus.sentDone, 4'b0001);
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("contend_rx_%0d", k), rxAt(startRx + k), expBytes[k]);
        end

        // Start timeout with the transmitter never reporting busy.
        uartDead = 1'b1;
        applyStimulus(4'b0010, 32'h00009900);
        for (n = 0; n < 200 && bus.reqReady == 0; n++) tick();
        checkOutput("to_ready", bus.reqReady, 4'b0010);
        tick();
        applyStimulus(4'h0, 32'h0);
        n = 0;
        while (bus.txStart == 1 && n < 40) begin
            n++;
            tick();
        end
        checkOutput("to_txStart_len", n, 16);
        checkOutput("to_sentErr", bus.sentErr, 4'b0010);
        checkOutput("to_idle", bus.busy, 0);
        checkOutput("to_no_done", bus.sentDone, 0);
        tick();
        checkOutput("to_err_one_cycle", bus.sentErr, 0);

        if (failCnt != 0) $display("[TB] %0d comparisons did not match", failCnt);
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one Uart8 transmitter among NUM_REQ byte producers (console, status reporter, loopback echo, etc.).
- Performs round-robin arbitration and a valid/ready handshake per requester, then sequences the Uart8 tx interface (txEn, txStart, txIn) and waits for completion.
- Reports completion or a start timeout back to the granted requester.
- Sits between the producer logic and the tx side of Uart8 in the top level.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 0, idle clk cycles inserted after each completed byte before the next grant (0..65535).
- START_TIMEOUT, 1024, clk cycles to wait for txBusy after asserting txStart before aborting.

Ports:
- clk  in  1  system clock, shared with Uart8.
- reset  in  1  asynchronous, active-high reset.
- reqValid  in  NUM_REQ  bit i: requester i has a byte to send.
- reqData  in  8*NUM_REQ  byte for requester i at [8i+7:8i].
- reqReady  out  NUM_REQ  one-hot pulse; byte i accepted this cycle.
- sentDone  out  NUM_REQ  one-cycle pulse on bit i when its byte has fully left Uart8.
- sentErr  out  NUM_REQ  one-cycle pulse on bit i on start timeout.
- grantId  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- busy  out  1  high whenever state != IDLE.
- txEn  out  1  to Uart8 txEn.
- txStart  out  1  to Uart8 txStart.
- txIn  out  8  to Uart8 txIn.
- txBusy  in  1  from Uart8.
- txDone  in  1  from Uart8.

Behaviour:
- Reset (async) values:
  - state = IDLE
  - txEn = 1
  - txStart = 0
  - txIn = 8'h00
  - reqReady = sentDone = sentErr = 0
  - grantId = 0
  - rrPtr = 0
  - busy = 0
- States:
  - IDLE, START, WAIT_DONE, GAP.
- IDLE:
  - If any reqValid is set, choose the first set bit at or after rrPtr, searching upward with wrap-around.
  - In the same cycle: pulse reqReady[g], latch txIn = reqData[g], set grantId = g, rrPtr = (g+1) mod NUM_REQ. Next state START.
  - Latency from reqValid to reqReady is 0 cycles when IDLE; txStart asserts on the following cycle.
- START:
  - txStart = 1; timeout counter increments.
  - On txBusy == 1: drop txStart in that cycle, go to WAIT_DONE.
  - If the counter reaches START_TIMEOUT-1 without txBusy: drop txStart, pulse sentErr[grantId], go to IDLE with no gap.
- WAIT_DONE:
  - txStart = 0.
  - When txBusy == 0 && txDone == 1: pulse sentDone[grantId].
  - Then go to GAP if GAP_CYCLES > 0, else to IDLE.
- GAP:
  - Count GAP_CYCLES cycles, then go to IDLE.
- Requester obligations:
  - A requester holds reqValid and reqData stable until it sees reqReady.
  - A requester may deassert reqValid before it is granted; the arbiter then ignores it.
- Simultaneous requests: only one grant per cycle. A non-granted requester keeps waiting and is served within NUM_REQ grants (fairness bound).
- Single active requester: it is re-granted back-to-back, subject to GAP.
- txIn holds the latched byte stable from START until the next grant; it is never changed while txBusy is high.
- A txDone that is already high on entry to WAIT_DONE from a previous byte is qualified by txBusy == 0, which cannot be true until the new frame ends because WAIT_DONE is entered only after txBusy == 1.
- Reset mid-transfer:
  - All outputs return to reset values immediately.
  - An in-flight Uart8 frame is not aborted by this block.
  - After reset the arbiter waits in IDLE until txBusy == 0 before granting.
- Counter widths:
  - Timeout counter: $clog2(START_TIMEOUT+1) bits.
  - Gap counter: 16 bits.
  - Both saturate, never wrap.

Decomposition:
- Shared package uart_ctrl_pkg holds:
  - state encoding (2-bit enum: IDLE=0, START=1, WAIT_DONE=2, GAP=3)
  - the UART_BYTE_W = 8 constant
- One natural sub-module, rr_pick: a combinational round-robin priority selector with inputs req[NUM_REQ] and ptr, and outputs gnt_onehot, gnt_idx, any. It is reused later by the rx dispatcher.

Test Plan:
- Single byte: reqValid[2] = 1, reqData[2] = 8'h8A, rrPtr = 0 -> reqReady[2] pulse, grantId = 2, txStart high until txBusy, sentDone[2] one cycle after the frame ends, and a Uart8 loopback receiver shows rxOut = 8'h8A.
- Contention: all four reqValid high at once with bytes 8'h11/22/33/44 -> bytes leave in order 0,1,2,3. With reqValid[0] re-asserted during byte 1, the order becomes 0,1,2,3,0 (wrap-around fairness).
- Gap: GAP_CYCLES = 100 with two queued bytes -> exactly 100 cycles between sentDone of the first byte and reqReady of the second.
- Timeout: txBusy tied 0, START_TIMEOUT = 16 -> txStart is high for exactly 16 cycles, sentErr[grantId] pulses once, then state returns to IDLE.
- Reset mid-frame: assert reset during WAIT_DONE -> busy, txStart and the pulse outputs go 0 asynchronously. After release, no grant is issued until txBusy falls.
- Withdrawn request: reqValid[1] pulses for 1 cycle while the arbiter is busy -> no grant to requester 1 and no reqReady[1].
